// File: rtl/spi_peripheral_if.sv
// SPI peripheral bus bundle: SPI pins plus the TX ready/valid and RX valid-pulse ports.
// The slave modport is the peripheral's view. The master modport is the view of whatever
// drives the pins and the byte interface (top level or testbench).
interface spi_peripheral_if;
  logic       i_sclk;
  logic       i_cs_n;
  logic       i_mosi;
  logic       o_miso;
  logic       o_miso_oe;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_busy;

  modport slave (
    input  i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
    output o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy
  );

  modport master (
    output i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
    input  o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral: oversamples SCLK/CS_n/MOSI in the i_clk domain and shifts 8-bit
// frames MSB-first in both directions. Back-to-back bytes are supported while CS_n stays low.
// It has a one-entry TX buffer (ready/valid) and a one-cycle RX valid pulse.
// Optional macro SPI_PERIPHERAL_STATUS_EN adds the o_underrun and o_frame_abort pulse outputs.
module spi_peripheral #(
  parameter int          SYNC_STAGES = 2,      // 2..3 flip-flops per SPI input
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF   // sent when the TX buffer is empty at a load
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  spi_peripheral_if.slave      bus
`ifdef SPI_PERIPHERAL_STATUS_EN
  ,
  output logic                 o_underrun,
  output logic                 o_frame_abort
`endif
);

  localparam logic [1:0] ST_WAIT_DESELECT = 2'd0;
  localparam logic [1:0] ST_IDLE          = 2'd1;
  localparam logic [1:0] ST_SHIFT         = 2'd2;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, primed_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_s, mosi_s, primed;
  logic                   sclk_rise, sclk_fall;

  // Datapath and control
  logic [1:0] state_q,    state_d;
  logic [3:0] bit_cnt_q,  bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       miso_q,     miso_d;
  logic       miso_oe_q,  miso_oe_d;
  logic [7:0] tx_buf_q,   tx_buf_d;
  logic       tx_full_q,  tx_full_d;
  logic       underrun_q, underrun_d;
  logic       abort_q,    abort_d;
  logic       load;
  logic       tx_accept;
  logic [7:0] load_byte;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign primed    = primed_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;

  assign tx_accept = bus.i_tx_valid & ~tx_full_q;
  assign load_byte = tx_full_q ? tx_buf_q : IDLE_BYTE;

  // Pin synchronizers. primed_q marks when the preset values have been flushed out, so
  // the state machine only reacts to a CS_n level it has actually seen on the pin.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      primed_q    <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous stage's old
      // value, which produces a real shift chain rather than one collapsed flop.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.i_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.i_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.i_mosi};
      primed_q    <= {primed_q[SYNC_STAGES-2:0],    1'b1};
      sclk_prev_q <= sclk_s;
    end
  end

  // Frame state machine: CS_n deselect wins over any SCLK edge in the same cycle
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    load       = 1'b0;
    abort_d    = 1'b0;

    case (state_q)
      ST_WAIT_DESELECT: begin
        if (primed && cs_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        miso_oe_d = 1'b0;
        if (!cs_s) begin
          load      = 1'b1;
          bit_cnt_d = 4'd0;
          miso_oe_d = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_s) begin
          abort_d   = (bit_cnt_q != 4'd0) && (bit_cnt_q != 4'd8);
          state_d   = ST_IDLE;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
          bit_cnt_d = 4'd0;
        end else if (sclk_rise && bit_cnt_q != 4'd8) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            rx_data_d  = {rx_shift_q[6:0], mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            load      = 1'b1;
          end else if (bit_cnt_q != 4'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            miso_d     = tx_shift_q[6];
          end
        end
      end
      default: state_d = ST_WAIT_DESELECT;
    endcase

    // A load always presents the new byte's MSB on MISO straight away
    if (load) begin
      tx_shift_d = load_byte;
      miso_d     = load_byte[7];
    end
    underrun_d = load & ~tx_full_q;
  end

  // TX buffer: a load empties it using the old contents, and an accept in the same cycle
  // refills it for the next byte, so there is no bypass path.
  always_comb begin
    tx_full_d = tx_full_q;
    tx_buf_d  = tx_buf_q;
    if (load) tx_full_d = 1'b0;
    if (tx_accept) begin
      tx_full_d = 1'b1;
      tx_buf_d  = bus.i_tx_data;
    end
  end

  // State, datapath and buffer registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_WAIT_DESELECT;
      bit_cnt_q  <= 4'd0;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      tx_buf_q   <= 8'h00;
      tx_full_q  <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.o_miso     = miso_q;
  assign bus.o_miso_oe  = miso_oe_q;
  assign bus.o_tx_ready = ~tx_full_q;
  assign bus.o_rx_data  = rx_data_q;
  assign bus.o_rx_valid = rx_valid_q;
  assign bus.o_busy     = (state_q == ST_SHIFT);

`ifdef SPI_PERIPHERAL_STATUS_EN
  assign o_underrun    = underrun_q;
  assign o_frame_abort = abort_q;
`else
  // Status pulses are not exported in this build
  logic unused_status;
  assign unused_status = underrun_q ^ abort_q;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral. The bench acts as an SPI mode-0 controller with an
// SCLK period of 8 i_clk cycles. It feeds the TX buffer from a queue and collects every
// o_rx_valid pulse.
`timescale 1ns/1ps
module tb_spi_peripheral;
  localparam int SYNC = 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  spi_peripheral_if bus ();

`ifdef SPI_PERIPHERAL_STATUS_EN
  logic o_underrun, o_frame_abort;
  int   n_underrun = 0, n_abort = 0;
`endif

  spi_peripheral #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
`ifdef SPI_PERIPHERAL_STATUS_EN
    ,
    .o_underrun    (o_underrun),
    .o_frame_abort (o_frame_abort)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge i_clk);
  endtask

  // Clock n bits of b MSB-first and return the MISO bits seen at each SCLK rise
  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      bus.i_mosi = b[i];
      half();
      miso = {miso[6:0], bus.o_miso};
      bus.i_sclk = 1'b1;
      half();
      bus.i_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge i_clk);
    bus.i_cs_n = 1'b0;
  endtask

  task automatic cs_high();
    half();
    bus.i_cs_n = 1'b1;
    repeat (8) @(negedge i_clk);
  endtask

  // TX feeder: presents queued bytes for one cycle whenever the buffer is ready
  initial begin
    bus.i_tx_valid = 1'b0;
    bus.i_tx_data  = 8'h00;
    forever begin
      @(negedge i_clk);
      if (bus.i_tx_valid) bus.i_tx_valid = 1'b0;
      else if (tx_q.size() > 0 && bus.o_tx_ready) begin
        bus.i_tx_data  = tx_q.pop_front();
        bus.i_tx_valid = 1'b1;
      end
    end
  end

  // RX collector (and status pulse counters when present)
  initial begin
    forever begin
      @(negedge i_clk);
      if (bus.o_rx_valid) rx_q.push_back(bus.o_rx_data);
`ifdef SPI_PERIPHERAL_STATUS_EN
      if (o_underrun)    n_underrun++;
      if (o_frame_abort) n_abort++;
`endif
    end
  end

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] m;
    bus.i_sclk = 1'b0;
    bus.i_cs_n = 1'b1;
    bus.i_mosi = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_miso",  {15'd0, bus.o_miso},     16'd0);
    check("rst_oe",    {15'd0, bus.o_miso_oe},  16'd0);
    check("rst_ready", {15'd0, bus.o_tx_ready}, 16'd1);
    check("rst_rx",    {8'd0, bus.o_rx_data},   16'h0000);
    check("rst_busy",  {15'd0, bus.o_busy},     16'd0);
    i_rst = 1'b0;
    repeat (6) @(negedge i_clk);

    // 1: TX A5, RX 3C
    tx_q.push_back(8'hA5);
    repeat (4) @(negedge i_clk);
    check("t1_ready_full", {15'd0, bus.o_tx_ready}, 16'd0);
    rx_q.delete();
    cs_low();
    half();
    check("t1_ready_after_load", {15'd0, bus.o_tx_ready}, 16'd1);
    check("t1_oe",   {15'd0, bus.o_miso_oe}, 16'd1);
    check("t1_busy", {15'd0, bus.o_busy},    16'd1);
    spi_bits(8'h3C, 8, m);
    check("t1_miso", {8'd0, m}, 16'h00A5);
    cs_high();
    check("t1_rx_count", 16'(rx_q.size()), 16'd1);
    if (rx_q.size() > 0) check("t1_rx", {8'd0, rx_q[0]}, 16'h003C);
    check("t1_oe_off", {15'd0, bus.o_miso_oe}, 16'd0);

    // 2: empty TX buffer, IDLE_BYTE out, RX 81
    rx_q.delete();
`ifdef SPI_PERIPHERAL_STATUS_EN
    n_underrun = 0;
`endif
    cs_low();
    half();
`ifdef SPI_PERIPHERAL_STATUS_EN
    check("t2_underrun", 16'(n_underrun), 16'd1);
`endif
    spi_bits(8'h81, 8, m);
    check("t2_miso", {8'd0, m}, 16'h00FF);
    cs_high();
    check("t2_rx_count", 16'(rx_q.size()), 16'd1);
    if (rx_q.size() > 0) check("t2_rx", {8'd0, rx_q[0]}, 16'h0081);

    // 3: back-to-back bytes
    rx_q.delete();
    tx_q.push_back(8'h10);
    tx_q.push_back(8'h20);
    tx_q.push_back(8'h30);
    repeat (4) @(negedge i_clk);
    cs_low();
    spi_bits(8'h01, 8, m);
    check("t3_miso0", {8'd0, m}, 16'h0010);
    spi_bits(8'h02, 8, m);
    check("t3_miso1", {8'd0, m}, 16'h0020);
    spi_bits(8'h03, 8, m);
    check("t3_miso2", {8'd0, m}, 16'h0030);
    cs_high();
    check("t3_rx_count", 16'(rx_q.size()), 16'd3);
    if (rx_q.size() == 3) begin
      check("t3_rx0", {8'd0, rx_q[0]}, 16'h0001);
      check("t3_rx1", {8'd0, rx_q[1]}, 16'h0002);
      check("t3_rx2", {8'd0, rx_q[2]}, 16'h0003);
    end
    check("t3_txq_drained", 16'(tx_q.size()), 16'd0);

    // 4: abort after 5 rises, then a clean frame
    rx_q.delete();
`ifdef SPI_PERIPHERAL_STATUS_EN
    n_abort = 0;
`endif
    cs_low();
    spi_bits(8'hF0, 5, m);
    @(negedge i_clk);
    bus.i_cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge i_clk);
    check("t4_oe_off", {15'd0, bus.o_miso_oe}, 16'd0);
    check("t4_busy",   {15'd0, bus.o_busy},    16'd0);
    repeat (6) @(negedge i_clk);
    check("t4_no_rx", 16'(rx_q.size()), 16'd0);
`ifdef SPI_PERIPHERAL_STATUS_EN
    check("t4_abort", 16'(n_abort), 16'd1);
`endif
    cs_low();
    spi_bits(8'hC3, 8, m);
    check("t4_miso", {8'd0, m}, 16'h00FF);
    cs_high();
    check("t4_rx_count", 16'(rx_q.size()), 16'd1);
    if (rx_q.size() > 0) check("t4_rx", {8'd0, rx_q[0]}, 16'h00C3);

    // 5: reset mid-frame with CS_n held low
    rx_q.delete();
    tx_q.push_back(8'h77);
    repeat (4) @(negedge i_clk);
    cs_low();
    spi_bits(8'hAA, 3, m);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("t5_rst_miso",  {15'd0, bus.o_miso},     16'd0);
    check("t5_rst_oe",    {15'd0, bus.o_miso_oe},  16'd0);
    check("t5_rst_ready", {15'd0, bus.o_tx_ready}, 16'd1);
    check("t5_rst_rx",    {8'd0, bus.o_rx_data},   16'h0000);
    check("t5_rst_busy",  {15'd0, bus.o_busy},     16'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    spi_bits(8'hFF, 8, m);
    repeat (4) @(negedge i_clk);
    check("t5_ignored_rx",   16'(rx_q.size()),     16'd0);
    check("t5_ignored_busy", {15'd0, bus.o_busy},  16'd0);
    check("t5_ignored_oe",   {15'd0, bus.o_miso_oe}, 16'd0);
    bus.i_cs_n = 1'b1;
    repeat (8) @(negedge i_clk);
    cs_low();
    spi_bits(8'h5A, 8, m);
    check("t5_miso", {8'd0, m}, 16'h00FF);
    cs_high();
    check("t5_rx_count", 16'(rx_q.size()), 16'd1);
    if (rx_q.size() > 0) check("t5_rx", {8'd0, rx_q[0]}, 16'h005A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
